// File: rtl/mem_pkg.sv
// Shared types and default sizes for the memory arbiter slice.
package mem_pkg;

    localparam int DEF_INW     = 512;
    localparam int DEF_ADDRW   = 32;
    localparam int DEF_TIMEOUT = 255;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: a lone requester always wins; on a tie the
// requester that was not granted last wins. grant is one-hot or zero.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // Pure combinational pick; last = 1 means requester 1 was served last.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port (r0) and a load-store port (r1) onto a single
// cache access path, one transaction outstanding, with a response timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no transaction; pick a winner, latch its command, pulse gnt
// ST_ISSUE | command latched; next cycle carries the mem_start strobe
// ST_WAIT  | access in flight; wait for mem_valid or timeout
// ST_RESP  | rvalid/err visible for the owner; update round-robin pointer
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int INW     = DEF_INW,
    parameter int ADDRW   = DEF_ADDRW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             r0_req,
    input  logic             r0_write,
    input  logic [ADDRW-1:0] r0_addr,
    input  logic [INW-1:0]   r0_wdata,
    output logic             r0_gnt,
    output logic             r0_rvalid,
    output logic             r0_err,

    input  logic             r1_req,
    input  logic             r1_write,
    input  logic [ADDRW-1:0] r1_addr,
    input  logic [INW-1:0]   r1_wdata,
    output logic             r1_gnt,
    output logic             r1_rvalid,
    output logic             r1_err,

    output logic [INW-1:0]   rdata,

    output logic             mem_start,
    output logic             mem_write,
    output logic [ADDRW-1:0] mem_addr,
    output logic [INW-1:0]   mem_wdata,
    input  logic             mem_valid,
    input  logic [INW-1:0]   mem_rdata
);

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_e             state_q;
    logic               owner_q;
    logic               last_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               r0_gnt_q, r1_gnt_q;
    logic               r0_rvalid_q, r1_rvalid_q;
    logic               r0_err_q, r1_err_q;
    logic               mem_start_q;
    logic               mem_write_q;
    logic [ADDRW-1:0]   mem_addr_q;
    logic [INW-1:0]     mem_wdata_q;
    logic [INW-1:0]     rdata_q;
    logic [1:0]         grant_d;

    rr_arb2 u_rr_arb2 (
        .req   ({r1_req, r0_req}),
        .last  (last_q),
        .grant (grant_d)
    );

    // Transaction FSM with all outputs registered. The timeout counter is held
    // during the mem_start cycle so it measures cycles after the launch strobe;
    // a success and a timeout on the same cycle resolve as success.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
            cnt_q       <= '0;
            r0_gnt_q    <= 1'b0;
            r1_gnt_q    <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_err_q    <= 1'b0;
            r1_err_q    <= 1'b0;
            mem_start_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            r0_gnt_q    <= 1'b0;
            r1_gnt_q    <= 1'b0;
            r0_rvalid_q <= 1'b0;
            r1_rvalid_q <= 1'b0;
            r0_err_q    <= 1'b0;
            r1_err_q    <= 1'b0;
            mem_start_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (|grant_d) begin
                        owner_q     <= grant_d[1];
                        mem_write_q <= grant_d[1] ? r1_write : r0_write;
                        mem_addr_q  <= grant_d[1] ? r1_addr  : r0_addr;
                        mem_wdata_q <= grant_d[1] ? r1_wdata : r0_wdata;
                        r0_gnt_q    <= grant_d[0];
                        r1_gnt_q    <= grant_d[1];
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_start_q <= 1'b1;
                    cnt_q       <= '0;
                    state_q     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        if (!mem_write_q) begin
                            rdata_q <= mem_rdata;
                        end
                        r0_rvalid_q <= ~owner_q;
                        r1_rvalid_q <= owner_q;
                        state_q     <= ST_RESP;
                    end else if (cnt_q == TO_CNT) begin
                        r0_rvalid_q <= ~owner_q;
                        r1_rvalid_q <= owner_q;
                        r0_err_q    <= ~owner_q;
                        r1_err_q    <= owner_q;
                        state_q     <= ST_RESP;
                    end else if (!mem_start_q) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    last_q  <= owner_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign r0_gnt    = r0_gnt_q;
    assign r1_gnt    = r1_gnt_q;
    assign r0_rvalid = r0_rvalid_q;
    assign r1_rvalid = r1_rvalid_q;
    assign r0_err    = r0_err_q;
    assign r1_err    = r1_err_q;
    assign rdata     = rdata_q;
    assign mem_start = mem_start_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter INW, default 512, cache line / data width in bits.
REQ-002 Parameter ADDRW, default 32, address width in bits.
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting for cache response (8-bit counter).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 r0_req / r1_req  in  1  requester 0 (fetch) / 1 (load-store) request, held until granted.
REQ-007 r0_write / r1_write  in  1  1 = write, 0 = read; qualified by req.
REQ-008 r0_addr / r1_addr  in  ADDRW  request address.
REQ-009 r0_wdata / r1_wdata  in  INW  write data.
REQ-010 r0_gnt / r1_gnt  out  1  one-cycle pulse: request accepted and latched.
REQ-011 r0_rvalid / r1_rvalid  out  1  one-cycle pulse: response complete.
REQ-012 r0_err / r1_err  out  1  valid with rvalid; 1 = timed out.
REQ-013 rdata  out  INW  response data, shared, valid with either rvalid.
REQ-014 mem_start  out  1  one-cycle strobe launching a cache access.
REQ-015 mem_write / mem_addr / mem_wdata  out  1/ADDRW/INW  cache command, stable from mem_start until response or timeout.
REQ-016 mem_valid  in  1  cache completion pulse.
REQ-017 mem_rdata  in  INW  cache read data, valid with mem_valid.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-019 IDLE: if any req, select winner, latch its write/addr/wdata, pulse its gnt, go ISSUE; else stay.
REQ-020 Arbitration: single requester wins; both requesting -> winner is the one not last granted (round-robin); last-granted pointer resets to 1, so r0 wins first tie.
REQ-021 ISSUE: mem_start = 1 for exactly one cycle, clear timeout counter, go WAIT.
REQ-022 WAIT: on mem_valid, capture mem_rdata into rdata (reads; writes keep rdata unchanged), err = 0, go RESP.
REQ-023 WAIT: counter increments each cycle without mem_valid; reaching TIMEOUT -> err = 1, rdata unchanged, go RESP.
REQ-024 mem_valid in the same cycle the counter reaches TIMEOUT SHALL count as success (err = 0).
REQ-025 RESP: pulse rvalid (and err) of the latched owner for one cycle, update last-granted pointer, go IDLE.
REQ-026 Request-to-response minimum latency SHALL be 4 cycles (gnt cycle T, mem_start T+1, mem_valid T+2, rvalid T+3).
REQ-027 mem_valid outside WAIT SHALL be ignored.
REQ-028 Requests arriving while not IDLE SHALL wait; gnt never asserted outside IDLE->ISSUE edge.
REQ-029 Requester dropping req before gnt SHALL lose nothing; no pending state kept.

Reset
REQ-030 rst_n low at a clock edge SHALL force IDLE, abandon any transaction without rvalid, clear counter.
REQ-031 Reset values: all gnt/rvalid/err/mem_start/mem_write = 0, mem_addr/mem_wdata/rdata = 0, pointer = 1.

Structure
REQ-032 State enum and default widths SHALL live in shared package mem_pkg.
REQ-033 Round-robin selection SHALL be sub-module rr_arb2 (req[1:0], last, grant[1:0]), combinational.
REQ-034 mem_arbiter sits between requesters and the cache wrapper; no other storage.

Verification
REQ-035 r0 read addr 0x40, cache returns 0xA5.. after 1 cycle -> r0_gnt T, mem_start T+1, r0_rvalid T+3, rdata = 0xA5.., err 0.
REQ-036 r0 and r1 request same cycle after reset -> r0 granted first, r1 granted in IDLE after r0 response; next tie goes to r0 again only after r1.
REQ-037 r1 write addr 0x80, mem_valid never returned -> r1_rvalid with r1_err = 1 exactly TIMEOUT+3 cycles after gnt, mem_write held 1.
REQ-038 mem_valid on cycle counter hits TIMEOUT -> err = 0, rdata captured.
REQ-039 rst_n low during WAIT -> next cycle all outputs 0, no rvalid; subsequent r1 request serviced normally.
REQ-040 spurious mem_valid in IDLE -> no rvalid, rdata unchanged.
